mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one memory/IO port among N_CORES PicoRV32 cores.
//  Each core presents a native valid/ready request (addr, wdata, wstrb). The
//  arbiter grants one request at a time and forwards it to the shared port.
//  It returns rdata and a one-cycle ready pulse to the winner, and flags an
//  error if the memory does not answer within TIMEOUT cycles.
//  It sits between the core array and the RAM/LED/UART decode in the SoC top.
// PARAMETERS
//  N_CORES   4    number of requesters, >=2, need not be a power of two
//  IDX_BITS  $clog2(N_CORES)  width of grant index (derived; do not override)
//  TIMEOUT   255  max cycles m_valid waits for m_ready before error, 1..255
//  ERR_RDATA 32'hDEADBEEF  rdata returned on timeout
// PORTS
//  clk        in   1         system clock, all logic on posedge
//  resetn     in   1         asynchronous active-low reset
//  req_valid  in   N_CORES   per-core request; held until its req_ready pulse
//  req_addr   in   32*N      per-core byte address, core k at [32k+31:32k]
//  req_wdata  in   32*N      per-core write data
//  req_wstrb  in   4*N       per-core byte strobes; 0 = read, !=0 = write
//  req_ready  out  N_CORES   one-cycle completion pulse, at most one bit set
//  req_rdata  out  32*N      per-core read data, valid while req_ready[k]=1
//  req_err    out  N_CORES   pulses with req_ready[k] when the access timed out
//  m_valid    out  1         shared-port request
//  m_addr     out  32        shared-port address
//  m_wdata    out  32        shared-port write data
//  m_wstrb    out  4         shared-port strobes
//  m_ready    in   1         shared-port completion; sampled only while m_valid=1
//  m_rdata    in   32        shared-port read data, valid with m_ready
//  grant_id   out  IDX_BITS  index of the current or last granted core
//  busy       out  1         1 while state != IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, rr_ptr=0, grant_id=0, timer=0.
//   All outputs are 0: m_valid, m_addr, m_wdata, m_wstrb, req_ready, req_err,
//   req_rdata and busy.
//  FSM states are IDLE -> ISSUE -> DONE -> IDLE.
//  IDLE:
//   - Scan from rr_ptr upward, modulo N_CORES; the first k with req_valid[k]=1 wins.
//   - On a win: latch that core's addr, wdata and wstrb into the m_* registers,
//     set m_valid=1, grant_id=k, timer=0, and go to ISSUE.
//   - Grant latency is 1 cycle from req_valid to m_valid.
//   - If no core requests, stay in IDLE.
//  ISSUE:
//   - m_* outputs stay stable. timer increments each cycle.
//   - If m_ready=1: capture m_rdata into req_rdata[grant_id], pulse
//     req_ready[grant_id] on the next cycle, drop m_valid, go to DONE.
//   - Else if timer==TIMEOUT-1: drop m_valid, load req_rdata[grant_id]=ERR_RDATA,
//     pulse req_ready and req_err on the next cycle, go to DONE.
//   - m_ready on the same cycle as the timeout wins: no error.
//  DONE:
//   - Lasts exactly one cycle; the req_ready/req_err pulse is visible during it.
//   - Set rr_ptr = grant_id+1, wrapping to 0 after N_CORES-1. Go to IDLE.
//   - No grant is made in DONE. This lets the winner deassert req_valid before
//     the next scan, so a stale request is never re-granted.
//  Throughput: an access that completes with zero wait costs 3 cycles.
//  Fairness: a continuously requesting core waits at most N_CORES-1 grants.
//  req_rdata[k] holds its value until core k's next completion. Other slices
//   are never modified.
//  Simultaneous requests are resolved by rr_ptr only. A request rising in ISSUE
//   or DONE is considered at the next IDLE.
//  If req_valid[grant_id] drops during ISSUE (protocol violation), the access
//   still completes and the ready pulse is still issued.
//  m_ready while m_valid=0 is ignored.
//  Reset asserted mid-access returns to the reset state immediately. Any
//   in-flight request is abandoned, with no ready or error pulse.
// TESTING
//  1 Single read: core2 reads 0x40, memory answers m_ready after 2 cycles with
//    0x12345678 -> m_valid 1 cycle after req_valid, m_addr=0x40, m_wstrb=0;
//    req_ready[2] pulses once with req_rdata[2]=0x12345678.
//  2 All 4 cores request at once from reset, zero-wait memory -> grant order
//    0,1,2,3; a new m_valid every 3 cycles; each req_ready pulses exactly once.
//  3 Fairness: core0 requests continuously, core3 raises a request once ->
//    core3 is granted within 3 grants; core0 is never granted twice in a row
//    while others wait.
//  4 Write: core1 writes 0xA5A5A5A5 with wstrb=4'b0011 to 0x10000000 ->
//    m_wdata and m_wstrb match; req_rdata[1] is unchanged from its prior value.
//  5 Timeout: TIMEOUT=8, m_ready held 0 -> m_valid high for 8 cycles, then
//    req_ready[k]=req_err[k]=1 with rdata 0xDEADBEEF. Repeat with m_ready on
//    the 8th cycle -> no error.
//  6 N_CORES=3: rr_ptr wraps 2->0. Then resetn pulses low in ISSUE -> outputs
//    are 0 asynchronously; no ready pulse after release; the next grant comes
//    from rr_ptr=0.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one native valid/ready memory port among N_CORES cores.
// Each access runs IDLE -> ISSUE -> DONE. The DONE cycle lets the winner drop req_valid before the next scan.
module mem_rr_arbiter #(
  parameter int          N_CORES   = 4,
  parameter int          IDX_BITS  = $clog2(N_CORES),
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_CORES-1:0]    req_valid,
  input  logic [32*N_CORES-1:0] req_addr,
  input  logic [32*N_CORES-1:0] req_wdata,
  input  logic [4*N_CORES-1:0]  req_wstrb,
  output logic [N_CORES-1:0]    req_ready,
  output logic [32*N_CORES-1:0] req_rdata,
  output logic [N_CORES-1:0]    req_err,
  output logic                  m_valid,
  output logic [31:0]           m_addr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic                  m_ready,
  input  logic [31:0]           m_rdata,
  output logic [IDX_BITS-1:0]   grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t                r_state;
  logic [IDX_BITS-1:0]   r_rr_ptr;
  logic [IDX_BITS-1:0]   r_grant_id;
  logic [7:0]            r_timer;
  logic                  r_m_valid;
  logic [31:0]           r_m_addr;
  logic [31:0]           r_m_wdata;
  logic [3:0]            r_m_wstrb;
  logic [N_CORES-1:0]    r_ready;
  logic [N_CORES-1:0]    r_err;
  logic [32*N_CORES-1:0] r_rdata;

  logic                  w_hi_found;
  logic                  w_lo_found;
  logic [IDX_BITS-1:0]   w_hi_idx;
  logic [IDX_BITS-1:0]   w_lo_idx;
  logic                  w_win;
  logic [IDX_BITS-1:0]   w_win_idx;
  logic [31:0]           w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [3:0]            w_sel_wstrb;
  logic [IDX_BITS-1:0]   w_next_ptr;

  // Rotating priority: the lowest requester at or above rr_ptr wins; otherwise the lowest requester overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      if (req_valid[k] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDX_BITS'(k);
      end
      if (req_valid[k] && !w_hi_found && (k >= 32'(r_rr_ptr))) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IDX_BITS'(k);
      end
    end
    w_win     = w_lo_found;
    w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      if (IDX_BITS'(k) == w_win_idx) begin
        w_sel_addr  = req_addr[k*32 +: 32];
        w_sel_wdata = req_wdata[k*32 +: 32];
        w_sel_wstrb = req_wstrb[k*4 +: 4];
      end
    end
  end

  assign w_next_ptr = (r_grant_id == IDX_BITS'(N_CORES-1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_timer    <= '0;
      r_m_valid  <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wstrb  <= '0;
      r_ready    <= '0;
      r_err      <= '0;
      r_rdata    <= '0;
    end else begin
      r_ready <= '0;
      r_err   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_win) begin
            r_m_valid  <= 1'b1;
            r_m_addr   <= w_sel_addr;
            r_m_wdata  <= w_sel_wdata;
            r_m_wstrb  <= w_sel_wstrb;
            r_grant_id <= w_win_idx;
            r_timer    <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= r_timer + 8'd1;
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= S_DONE;
            // A write completion returns no data, so the core's last read value is kept.
            for (int unsigned k = 0; k < N_CORES; k++) begin
              if (IDX_BITS'(k) == r_grant_id) begin
                r_ready[k] <= 1'b1;
                if (r_m_wstrb == 4'b0000) r_rdata[k*32 +: 32] <= m_rdata;
              end
            end
          end else if (r_timer == 8'(TIMEOUT-1)) begin
            r_m_valid <= 1'b0;
            r_state   <= S_DONE;
            for (int unsigned k = 0; k < N_CORES; k++) begin
              if (IDX_BITS'(k) == r_grant_id) begin
                r_ready[k]          <= 1'b1;
                r_err[k]            <= 1'b1;
                r_rdata[k*32 +: 32] <= ERR_RDATA;
              end
            end
          end
        end
        S_DONE: begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign req_err   = r_err;
  assign req_rdata = r_rdata;
  assign m_valid   = r_m_valid;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign m_wstrb   = r_m_wstrb;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a 4-core instance with TIMEOUT=8 and a 3-core instance.
module tb_mem_rr_arbiter;

  logic clk;
  int   n_tests;
  int   n_fail;

  // 4-core instance
  logic         a_resetn;
  logic [3:0]   a_req_valid;
  logic [127:0] a_req_addr;
  logic [127:0] a_req_wdata;
  logic [15:0]  a_req_wstrb;
  logic [3:0]   a_req_ready;
  logic [127:0] a_req_rdata;
  logic [3:0]   a_req_err;
  logic         a_m_valid;
  logic [31:0]  a_m_addr;
  logic [31:0]  a_m_wdata;
  logic [3:0]   a_m_wstrb;
  logic         a_m_ready;
  logic [31:0]  a_m_rdata;
  logic [1:0]   a_grant_id;
  logic         a_busy;

  // 3-core instance
  logic         b_resetn;
  logic [2:0]   b_req_valid;
  logic [95:0]  b_req_addr;
  logic [95:0]  b_req_wdata;
  logic [11:0]  b_req_wstrb;
  logic [2:0]   b_req_ready;
  logic [95:0]  b_req_rdata;
  logic [2:0]   b_req_err;
  logic         b_m_valid;
  logic [31:0]  b_m_addr;
  logic [31:0]  b_m_wdata;
  logic [3:0]   b_m_wstrb;
  logic         b_m_ready;
  logic [31:0]  b_m_rdata;
  logic [1:0]   b_grant_id;
  logic         b_busy;

  mem_rr_arbiter #(.N_CORES(4), .TIMEOUT(8)) dut4 (
    .clk(clk), .resetn(a_resetn),
    .req_valid(a_req_valid), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .req_ready(a_req_ready), .req_rdata(a_req_rdata), .req_err(a_req_err),
    .m_valid(a_m_valid), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb),
    .m_ready(a_m_ready), .m_rdata(a_m_rdata), .grant_id(a_grant_id), .busy(a_busy)
  );

  mem_rr_arbiter #(.N_CORES(3), .TIMEOUT(8)) dut3 (
    .clk(clk), .resetn(b_resetn),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .req_ready(b_req_ready), .req_rdata(b_req_rdata), .req_err(b_req_err),
    .m_valid(b_m_valid), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
    .m_ready(b_m_ready), .m_rdata(b_m_rdata), .grant_id(b_grant_id), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    a_resetn = 1'b0; a_req_valid = '0; a_req_addr = '0; a_req_wdata = '0; a_req_wstrb = '0;
    a_m_ready = 1'b0; a_m_rdata = '0;
    b_resetn = 1'b0; b_req_valid = '0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    b_m_ready = 1'b0; b_m_rdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_m_valid", 32'(a_m_valid), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_grant", 32'(a_grant_id), 0);
    chk("rst_ready", 32'(a_req_ready), 0);
    chk("rst_m_addr", a_m_addr, 0);
    chk("rst_rdata2", a_req_rdata[64 +: 32], 0);
    a_resetn = 1'b1;
    tick();
    chk("idle_busy", 32'(a_busy), 0);

    // 1: single read by core2, memory answers after two cycles
    a_req_addr[64 +: 32] = 32'h40;
    a_req_valid = 4'b0100;
    tick();
    chk("t1_m_valid", 32'(a_m_valid), 1);
    chk("t1_m_addr", a_m_addr, 32'h40);
    chk("t1_m_wstrb", 32'(a_m_wstrb), 0);
    chk("t1_grant", 32'(a_grant_id), 2);
    chk("t1_busy", 32'(a_busy), 1);
    tick();
    chk("t1_wait_ready", 32'(a_req_ready), 0);
    chk("t1_wait_valid", 32'(a_m_valid), 1);
    a_m_ready = 1'b1; a_m_rdata = 32'h12345678;
    tick();
    chk("t1_ready", 32'(a_req_ready), 32'h4);
    chk("t1_rdata", a_req_rdata[64 +: 32], 32'h12345678);
    chk("t1_m_valid_drop", 32'(a_m_valid), 0);
    a_req_valid = '0; a_m_ready = 1'b0;
    tick();
    chk("t1_ready_once", 32'(a_req_ready), 0);
    chk("t1_rdata_hold", a_req_rdata[64 +: 32], 32'h12345678);

    // 2: all four cores from reset, zero-wait memory
    a_resetn = 1'b0;
    #1;
    chk("t2_async_rdata", a_req_rdata[64 +: 32], 0);
    tick();
    a_resetn = 1'b1;
    for (int k = 0; k < 4; k++) a_req_addr[k*32 +: 32] = 32'h100 * (k + 1);
    a_req_valid = 4'b1111;
    a_m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_m_rdata = 32'hC0DE0000 | k;
      tick();
      chk("t2_grant", 32'(a_grant_id), k);
      chk("t2_m_valid", 32'(a_m_valid), 1);
      chk("t2_m_addr", a_m_addr, 32'h100 * (k + 1));
      tick();
      chk("t2_ready", 32'(a_req_ready), 32'h1 << k);
      chk("t2_rdata", a_req_rdata[k*32 +: 32], 32'hC0DE0000 | k);
      a_req_valid[k] = 1'b0;
      tick();
      chk("t2_gap_valid", 32'(a_m_valid), 0);
      chk("t2_gap_ready", 32'(a_req_ready), 0);
    end

    // 3: core0 continuously requesting, core3 raises once (rr_ptr now 0)
    a_req_valid = 4'b0001;
    tick();
    chk("t3_grant0", 32'(a_grant_id), 0);
    a_req_valid[3] = 1'b1;
    tick(); tick();
    tick();
    chk("t3_grant3", 32'(a_grant_id), 3);
    tick();
    chk("t3_ready3", 32'(a_req_ready), 32'h8);
    a_req_valid[3] = 1'b0;
    tick();
    tick();
    chk("t3_grant0_again", 32'(a_grant_id), 0);
    tick();
    a_req_valid[0] = 1'b0;
    tick();

    // 4: core1 write; its previous read data must survive (rr_ptr now 1)
    a_req_addr[32 +: 32] = 32'h10000000;
    a_req_wdata[32 +: 32] = 32'hA5A5A5A5;
    a_req_wstrb[4 +: 4] = 4'b0011;
    a_m_rdata = 32'hFFFFFFFF;
    a_req_valid = 4'b0010;
    tick();
    chk("t4_grant", 32'(a_grant_id), 1);
    chk("t4_m_addr", a_m_addr, 32'h10000000);
    chk("t4_m_wdata", a_m_wdata, 32'hA5A5A5A5);
    chk("t4_m_wstrb", 32'(a_m_wstrb), 32'h3);
    tick();
    chk("t4_ready", 32'(a_req_ready), 32'h2);
    chk("t4_rdata_kept", a_req_rdata[32 +: 32], 32'hC0DE0001);
    a_req_valid = '0; a_m_ready = 1'b0;
    tick();

    // 5a: timeout on core2 (rr_ptr now 2)
    a_req_valid = 4'b0100;
    tick();
    chk("t5_m_valid_c1", 32'(a_m_valid), 1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk("t5_m_valid_hold", 32'(a_m_valid), 1);
      chk("t5_no_ready", 32'(a_req_ready), 0);
    end
    tick();
    chk("t5_m_valid_drop", 32'(a_m_valid), 0);
    chk("t5_ready", 32'(a_req_ready), 32'h4);
    chk("t5_err", 32'(a_req_err), 32'h4);
    chk("t5_rdata", a_req_rdata[64 +: 32], 32'hDEADBEEF);
    a_req_valid = '0;
    tick();
    chk("t5_err_clear", 32'(a_req_err), 0);

    // 5b: m_ready in the 8th cycle beats the timeout (core3)
    a_req_wstrb = '0;
    a_req_valid = 4'b1000;
    tick();
    for (int c = 2; c <= 8; c++) tick();
    chk("t5b_m_valid_c8", 32'(a_m_valid), 1);
    a_m_ready = 1'b1; a_m_rdata = 32'hCAFEF00D;
    tick();
    chk("t5b_ready", 32'(a_req_ready), 32'h8);
    chk("t5b_no_err", 32'(a_req_err), 0);
    chk("t5b_rdata", a_req_rdata[96 +: 32], 32'hCAFEF00D);
    a_req_valid = '0; a_m_ready = 1'b0;
    tick();

    // 6: three cores, pointer wrap, reset mid-access
    b_resetn = 1'b1;
    b_m_ready = 1'b1;
    b_req_valid = 3'b100;
    tick();
    chk("t6_grant2", 32'(b_grant_id), 2);
    tick();
    chk("t6_ready2", 32'(b_req_ready), 32'h4);
    b_req_valid = 3'b000;
    tick();
    b_req_valid = 3'b101;
    tick();
    chk("t6_wrap_grant0", 32'(b_grant_id), 0);
    tick();
    b_req_valid = 3'b110;
    tick();
    tick();
    b_m_ready = 1'b0;
    tick();
    chk("t6_grant1", 32'(b_grant_id), 1);
    chk("t6_issue_valid", 32'(b_m_valid), 1);
    b_resetn = 1'b0;
    #1;
    chk("t6_async_valid", 32'(b_m_valid), 0);
    chk("t6_async_busy", 32'(b_busy), 0);
    chk("t6_async_grant", 32'(b_grant_id), 0);
    chk("t6_async_addr", b_m_addr, 0);
    b_req_valid = '0;
    b_m_ready = 1'b1;
    tick();
    b_resetn = 1'b1;
    tick();
    chk("t6_no_ready", 32'(b_req_ready), 0);
    tick();
    chk("t6_no_ready2", 32'(b_req_ready), 0);
    chk("t6_idle_valid", 32'(b_m_valid), 0);
    b_req_valid = 3'b101;
    tick();
    chk("t6_post_rst_grant", 32'(b_grant_id), 0);
    tick();
    b_req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
